// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency lookup of 16-bit words with flush and a busy/PC-hold output.
// Optional one-entry last-fetch buffer under `IMEM_HIT_BUF_EN` gives next-cycle responses for repeat addresses.
module imem_fetch_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        busy
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [ADDR_W-1:0]   addr_q, addr_q_n;
    logic [15:0]         instr_n;
    logic                valid_n;
    logic                load;
    logic                hit;
    logic [ADDR_W-1:0]   req_word, wr_word;
    logic [15:0]         rd_data;
    logic [15:0]         mem [0:(2**ADDR_W)-1];

    assign req_word = addr[ADDR_W:1];
    assign wr_word  = wr_addr[ADDR_W:1];
    assign rd_data  = mem[addr_q];
    assign busy     = (state == WAIT);

    logic unused_bits;
    assign unused_bits = ^{addr[15:ADDR_W+1], addr[0], wr_addr[15:ADDR_W+1], wr_addr[0]};

`ifdef IMEM_HIT_BUF_EN
    logic              hb_valid;
    logic [ADDR_W-1:0] hb_tag;
    logic [15:0]       hb_data;
    logic [ADDR_W-1:0] hb_tag_n;

    assign hit      = hb_valid && (req_word == hb_tag);
    assign hb_tag_n = load ? addr_q : hb_tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hb_valid <= 1'b0;
        end else if (load) begin
            hb_valid <= 1'b1;
        end
    end

    // A same-edge write to the buffered word wins so the buffer never goes stale.
    always_ff @(posedge clk) begin
        hb_tag <= hb_tag_n;
        if (wr_en && (wr_word == hb_tag_n)) begin
            hb_data <= wr_data;
        end else if (load) begin
            hb_data <= rd_data;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_q_n = addr_q;
        instr_n  = instr;
        valid_n  = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (req && hit) begin
`ifdef IMEM_HIT_BUF_EN
                    instr_n = hb_data;
`endif
                    valid_n = 1'b1;
                end else if (req) begin
                    addr_q_n = req_word;
                    cnt_n    = CNT_INIT;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    if (req) begin
                        addr_q_n = req_word;
                        cnt_n    = CNT_INIT;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (cnt == 4'd0) begin
                    load    = 1'b1;
                    instr_n = rd_data;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            addr_q      <= addr_q_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
        end
    end

    // Writes ignore reset; a load at the same edge still sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_word] <= wr_data;
        end
    end
endmodule
